// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter family: FSM state encoding,
// legal ranges for the frame-shape parameters and the bit-period helper.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_e;

    // Number of system clocks per serial bit, truncated to an integer.
    function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side word handshake of the UART transmitter. The producer (master)
// offers a word with tx_valid; the transmitter (slave) takes it while
// tx_ready is high and reports an in-flight frame on tx_busy.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts system clocks while enabled and pulses tick for
// one cycle at the terminal count; the count is held at zero while disabled
// so every enabled stretch starts a full bit period. Usable by a receiver too.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;

    // Free-running bit counter, cleared by reset, by disable and on wrap.
    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            count_q <= '0;
        end else if (count_q == LAST_COUNT) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign tick = en && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit and STOP_BITS stop bits, all timed from the system
// clock through uart_baud_gen. The line output is registered, so the start
// bit appears one clock after the word is accepted.
// Optional feature macro: UART_TX_PARITY_EN (parity bit, sense PARITY_ODD).
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_tx_param_if.slave  bus,
    output logic            tx_serial
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_e       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 serial_q;
    logic                 line_bit;
    logic                 baud_tick;

`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 parity_bit;

    // Parity comes from the word as accepted, not from the shifted remainder.
    assign parity_bit = (^word_q) ^ (PARITY_ODD != 0);
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_q != ST_IDLE),
        .tick    (baud_tick)
    );

    // Next-state, datapath updates and the current line level of the frame.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        line_bit   = 1'b1;
`ifdef UART_TX_PARITY_EN
        word_d     = word_q;
`endif
        case (state_q)
            ST_IDLE: begin
                line_bit = 1'b1;
                if (bus.tx_valid) begin
                    shift_d    = bus.tx_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    word_d     = bus.tx_data;
`endif
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                line_bit = 1'b0;
                if (baud_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                line_bit = shift_q[0];
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                line_bit = parity_bit;
                if (baud_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                line_bit = 1'b1;
                if (baud_tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        stop_idx_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            serial_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            word_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            serial_q   <= line_bit;
`ifdef UART_TX_PARITY_EN
            word_q     <= word_d;
`endif
        end
    end

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign bus.tx_busy  = (state_q != ST_IDLE);
    assign tx_serial    = serial_q;

endmodule
